// File: rtl/nes_mem_pkg.sv
// nes_mem_pkg
// Shared definitions for the NES CPU-bus slave blocks: bus widths, the
// clear-sequencer state type and the address-window decode helpers.
// No ports (package).

package nes_mem_pkg;

    localparam int REG_WIDTH  = 8;
    localparam int ADDR_WIDTH = 16;

    // One bit wider than the bus so that BASE+SPAN == 2^ADDR_WIDTH and the
    // subtraction borrow are both representable.
    typedef logic [ADDR_WIDTH:0] bus_off_t;

    typedef enum logic {
        CLR_IDLE = 1'b0,
        CLR_RUN  = 1'b1
    } clr_state_t;

    function automatic logic win_hit(input bus_off_t addr,
                                     input bus_off_t base,
                                     input bus_off_t span);
        bus_off_t off;
        off = addr - base;
        return (addr >= base) && (off < span);
    endfunction

    function automatic bus_off_t win_off(input bus_off_t addr,
                                         input bus_off_t base);
        return addr - base;
    endfunction

endpackage

// File: rtl/nes_mem_bank_if.sv
// nes_mem_bank_if
// CPU-side bus bundle for one memory bank.
//   en, we, addr, din       : driven by the bus master
//   dout, dout_valid, hit,
//   busy, wr_err            : driven by the bank

interface nes_mem_bank_if #(
    parameter int WIDTH      = nes_mem_pkg::REG_WIDTH,
    parameter int ADDR_WIDTH = nes_mem_pkg::ADDR_WIDTH
);
    logic                  en;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      din;
    logic [WIDTH-1:0]      dout;
    logic                  dout_valid;
    logic                  hit;
    logic                  busy;
    logic                  wr_err;

    modport master (
        output en, we, addr, din,
        input  dout, dout_valid, hit, busy, wr_err
    );

    modport slave (
        input  en, we, addr, din,
        output dout, dout_valid, hit, busy, wr_err
    );
endinterface

// File: rtl/nes_mem_array.sv
// nes_mem_array
// Single-port synchronous WIDTH x DEPTH storage with registered read, kept
// in its own module so FPGA tools infer block RAM.
//   clk        : clock
//   we         : write enable (wdata -> mem[addr])
//   re         : read enable (mem[addr] -> rdata on the edge)
//   addr       : word index
//   wdata      : write data
//   rdata      : registered read data (holds last read)
//   preload_ok : (TEST_RUN only) high while reset is asserted

module nes_mem_array #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2048
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
`ifdef TEST_RUN
    input  logic                     preload_ok,
`endif
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

`ifdef TEST_RUN
    // Preload port driven hierarchically by a test harness; honoured only
    // while the bank is held in reset.
    logic                     pre_en;
    logic [$clog2(DEPTH)-1:0] pre_idx;
    logic [WIDTH-1:0]         pre_data;

    function automatic logic [WIDTH-1:0] peek(input logic [$clog2(DEPTH)-1:0] idx);
        return mem[idx];
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
`ifdef TEST_RUN
        else if (preload_ok && pre_en) begin
            mem[pre_idx] <= pre_data;
        end
`endif
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/nes_mem_bank.sv
// nes_mem_bank
// Address-decoded memory bank for the 6502/NES bus: base/span window with
// power-of-two mirroring, registered read with valid flag, optional ROM mode
// with write-violation pulse, and a post-reset clear sequencer.
//   clk   : system clock, rising edge
//   reset : synchronous, active high
//   bus   : nes_mem_bank_if slave (en/we/addr/din in; dout/dout_valid/hit/
//           busy/wr_err out)
//
// Clear FSM:
//   state    | meaning
//   CLR_IDLE | normal bus access
//   CLR_RUN  | writing FILL_VALUE to mem[ptr], one word per cycle; bus ignored

module nes_mem_bank #(
    parameter int          WIDTH          = nes_mem_pkg::REG_WIDTH,
    parameter int          ADDR_WIDTH     = nes_mem_pkg::ADDR_WIDTH,
    parameter int          DEPTH          = 2048,
    parameter int unsigned BASE           = 32'h0000,
    parameter int unsigned SPAN           = 32'h2000,
    parameter bit          READ_ONLY      = 1'b0,
    parameter bit          CLEAR_ON_RESET = 1'b1,
    parameter logic [WIDTH-1:0] FILL_VALUE = '0
) (
    input logic           clk,
    input logic           reset,
    nes_mem_bank_if.slave bus
);
    import nes_mem_pkg::*;

    localparam int LW = $clog2(DEPTH);

    clr_state_t             state, state_next;
    logic [LW-1:0]          ptr, ptr_next;
    logic [ADDR_WIDTH-1:0]  bus_addr;
    logic [LW-1:0]          local_idx;
    logic                   in_win, busy, accept;
    logic                   rd_acc, wr_acc, rom_err, clr_wr;
    logic                   rd_valid, wr_err_q;
    logic                   mem_we;
    logic [LW-1:0]          mem_addr;
    logic [WIDTH-1:0]       mem_wdata, mem_rdata;

    assign bus_addr  = bus.addr;
    assign in_win    = win_hit(bus_off_t'(bus_addr), bus_off_t'(BASE), bus_off_t'(SPAN));
    // Low bits of the window offset: mirrors every DEPTH addresses.
    assign local_idx = LW'(win_off(bus_off_t'(bus_addr), bus_off_t'(BASE)));

    assign busy    = (state == CLR_RUN);
    assign accept  = bus.en && in_win && !busy && !reset;
    assign rd_acc  = accept && !bus.we;
    assign wr_acc  = accept && bus.we && !READ_ONLY;
    assign rom_err = accept && bus.we && READ_ONLY;
    // While reset is held the FSM sits in CLR_RUN with ptr=0; suppress the
    // write so the sequence starts cleanly on the first released cycle.
    assign clr_wr  = busy && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR_ON_RESET ? CLR_RUN : CLR_IDLE;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        if (state == CLR_RUN) begin
            ptr_next = ptr + 1'b1;
            if (ptr == LW'(DEPTH - 1)) begin
                state_next = CLR_IDLE;
                ptr_next   = '0;
            end
        end
    end

    // Clear and bus writes never overlap: accept is gated by !busy.
    assign mem_we    = clr_wr || wr_acc;
    assign mem_addr  = clr_wr ? ptr : local_idx;
    assign mem_wdata = clr_wr ? FILL_VALUE : bus.din;

    nes_mem_array #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_array (
        .clk        (clk),
        .we         (mem_we),
        .re         (rd_acc),
        .addr       (mem_addr),
        .wdata      (mem_wdata),
`ifdef TEST_RUN
        .preload_ok (reset),
`endif
        .rdata      (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            wr_err_q <= rom_err;
        end
    end

    assign bus.hit        = bus.en && in_win;
    assign bus.busy       = busy;
    assign bus.dout_valid = rd_valid;
    assign bus.dout       = rd_valid ? mem_rdata : '0;
    assign bus.wr_err     = wr_err_q;

endmodule

// File: tb/tb_nes_mem_bank.sv
// tb_nes_mem_bank
// Two banks: A = 2 KiB RAM mirrored over $0000-$1FFF (fill 0x00);
// B = 256-word ROM at $6000-$7FFF filled with 0x3C by the clear sequencer.
// A behavioural model of both banks is checked on every falling edge,
// with directed literal checks from the stimulus thread.

module tb_nes_mem_bank;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    nes_mem_bank_if #(.WIDTH(8), .ADDR_WIDTH(16)) ifa ();
    nes_mem_bank_if #(.WIDTH(8), .ADDR_WIDTH(16)) ifb ();

    nes_mem_bank #(
        .WIDTH(8), .ADDR_WIDTH(16), .DEPTH(2048), .BASE(32'h0000), .SPAN(32'h2000),
        .READ_ONLY(1'b0), .CLEAR_ON_RESET(1'b1), .FILL_VALUE(8'h00)
    ) dut_a (.clk(clk), .reset(rst_a), .bus(ifa));

    nes_mem_bank #(
        .WIDTH(8), .ADDR_WIDTH(16), .DEPTH(256), .BASE(32'h6000), .SPAN(32'h2000),
        .READ_ONLY(1'b1), .CLEAR_ON_RESET(1'b1), .FILL_VALUE(8'h3C)
    ) dut_b (.clk(clk), .reset(rst_b), .bus(ifb));

    // ---------------- model ----------------
    int         base_p [2] = '{32'h0000, 32'h6000};
    int         span_p [2] = '{32'h2000, 32'h2000};
    int         depth_p[2] = '{2048, 256};
    bit         ro_p   [2] = '{1'b0, 1'b1};
    logic [7:0] fill_p [2] = '{8'h00, 8'h3C};
    string      nm     [2] = '{"a", "b"};

    logic [7:0] mm [2][2048];
    int         left   [2] = '{0, 0};     // busy cycles remaining, incl. current
    bit         known  [2] = '{0, 0};
    logic [7:0] e_dout [2];
    bit         e_valid[2];
    bit         e_err  [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_step(input int i, input logic rst, input logic en, input logic we,
                              input logic [15:0] addr, input logic [7:0] din,
                              input logic hit, input logic busy, input logic [7:0] dout,
                              input logic valid, input logic err);
        bit in_w, acc;
        int li;
        in_w = (int'(addr) >= base_p[i]) && (int'(addr) < base_p[i] + span_p[i]);
        chk({nm[i], ".hit"}, 32'(hit), 32'(en && in_w));
        if (known[i]) begin
            chk({nm[i], ".busy"},       32'(busy),  32'(left[i] > 0));
            chk({nm[i], ".dout"},       32'(dout),  32'(e_dout[i]));
            chk({nm[i], ".dout_valid"}, 32'(valid), 32'(e_valid[i]));
            chk({nm[i], ".wr_err"},     32'(err),   32'(e_err[i]));
        end
        if (rst === 1'b1) begin
            // Accesses are blocked until the clear completes, so the
            // contents can be treated as filled at once.
            left[i] = depth_p[i];
            for (int k = 0; k < depth_p[i]; k++) mm[i][k] = fill_p[i];
            e_dout[i]  = 8'h00;
            e_valid[i] = 1'b0;
            e_err[i]   = 1'b0;
            known[i]   = 1'b1;
        end else begin
            acc = en && in_w && (left[i] == 0);
            li  = acc ? (int'(addr) - base_p[i]) % depth_p[i] : 0;
            e_valid[i] = acc && !we;
            e_dout[i]  = (acc && !we) ? mm[i][li] : 8'h00;
            e_err[i]   = acc && we && ro_p[i];
            if (acc && we && !ro_p[i]) mm[i][li] = din;
            if (left[i] > 0) left[i]--;
        end
    endtask

    always @(negedge clk) begin
        model_step(0, rst_a, ifa.en, ifa.we, ifa.addr, ifa.din,
                   ifa.hit, ifa.busy, ifa.dout, ifa.dout_valid, ifa.wr_err);
        model_step(1, rst_b, ifb.en, ifb.we, ifb.addr, ifb.din,
                   ifb.hit, ifb.busy, ifb.dout, ifb.dout_valid, ifb.wr_err);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int i, input bit en, input bit we,
                       input logic [15:0] a, input logic [7:0] d);
        if (i == 0) begin
            ifa.en = en; ifa.we = we; ifa.addr = a; ifa.din = d;
        end else begin
            ifb.en = en; ifb.we = we; ifb.addr = a; ifb.din = d;
        end
    endtask

    task automatic wr1(input int i, input logic [15:0] a, input logic [7:0] d);
        tick(); drv(i, 1, 1, a, d);
        tick(); drv(i, 0, 0, 16'h0000, 8'h00);
    endtask

    task automatic rd1(input int i, input logic [15:0] a, input logic [7:0] exp, input string name);
        tick(); drv(i, 1, 0, a, 8'h00);
        tick(); drv(i, 0, 0, 16'h0000, 8'h00);
        @(negedge clk);
        chk(name, (i == 0) ? 32'(ifa.dout) : 32'(ifb.dout), 32'(exp));
        chk({name, ".valid"}, (i == 0) ? 32'(ifa.dout_valid) : 32'(ifb.dout_valid), 32'd1);
    endtask

    // Counts A's busy cycles from the current cycle on; optionally attempts
    // a write of 0x55 to $0010 in the first busy cycle.
    task automatic count_busy_a(input bit poke, output int n);
        n = 0;
        if (poke) drv(0, 1, 1, 16'h0010, 8'h55);
        for (int k = 0; k < 6000; k++) begin
            @(negedge clk);
            if (k == 0 && poke) #2 drv(0, 0, 0, 16'h0000, 8'h00);
            if (ifa.busy) n++;
            else break;
        end
    endtask

    logic [15:0] edge_addr[4] = '{16'h5FFF, 16'h8000, 16'h6000, 16'h7FFF};
    bit          edge_hit [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0]  pipe_val [3] = '{8'h11, 8'h22, 8'h33};

    initial begin
        int n;
        rst_a = 1'b1; rst_b = 1'b1;
        drv(0, 0, 0, 16'h0000, 8'h00);
        drv(1, 0, 0, 16'h0000, 8'h00);
        repeat (3) tick();
        @(negedge clk);
        chk("rst.a.dout", 32'(ifa.dout), 32'h0);
        chk("rst.a.valid", 32'(ifa.dout_valid), 32'h0);
        chk("rst.a.wr_err", 32'(ifa.wr_err), 32'h0);
        chk("rst.a.busy", 32'(ifa.busy), 32'h1);
        chk("rst.b.busy", 32'(ifb.busy), 32'h1);

        // Clear after reset, with a dropped write during busy
        tick(); rst_a = 1'b0; rst_b = 1'b0;
        count_busy_a(1'b1, n);
        chk("clear_len", 32'(n), 32'd2048);
        rd1(0, 16'h0010, 8'h00, "rd_after_clear");

        // Mirroring
        wr1(0, 16'h0005, 8'hA5);
        rd1(0, 16'h0805, 8'hA5, "mirror_0805");
        rd1(0, 16'h1005, 8'hA5, "mirror_1005");
        rd1(0, 16'h1805, 8'hA5, "mirror_1805");

        // Write then read the same location in consecutive cycles
        tick(); drv(0, 1, 1, 16'h0123, 8'h5A);
        tick(); drv(0, 1, 0, 16'h0123, 8'h00);
        tick(); drv(0, 0, 0, 16'h0000, 8'h00);
        @(negedge clk);
        chk("wr_then_rd", 32'(ifa.dout), 32'h5A);

        // Pipelined reads
        for (int k = 0; k < 3; k++) wr1(0, 16'(k + 1), pipe_val[k]);
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k < 3) drv(0, 1, 0, 16'(k + 1), 8'h00);
            else       drv(0, 0, 0, 16'h0000, 8'h00);
            if (k > 0) begin
                @(negedge clk);
                chk("pipe.dout", 32'(ifa.dout), 32'(pipe_val[k-1]));
                chk("pipe.valid", 32'(ifa.dout_valid), 32'd1);
            end
        end

        // Window edges on B
        for (int k = 0; k < 4; k++) begin
            tick(); drv(1, 1, 0, edge_addr[k], 8'h00);
            @(negedge clk);
            chk("edge.hit", 32'(ifb.hit), 32'(edge_hit[k]));
            tick(); drv(1, 0, 0, 16'h0000, 8'h00);
            @(negedge clk);
            chk("edge.valid", 32'(ifb.dout_valid), 32'(edge_hit[k]));
            chk("edge.dout", 32'(ifb.dout), edge_hit[k] ? 32'h3C : 32'h0);
        end

        // ROM write violation
        tick(); drv(1, 1, 1, 16'h6000, 8'hFF);
        tick(); drv(1, 0, 0, 16'h0000, 8'h00);
        @(negedge clk);
        chk("rom.wr_err", 32'(ifb.wr_err), 32'd1);
        tick();
        @(negedge clk);
        chk("rom.wr_err_drop", 32'(ifb.wr_err), 32'd0);
        rd1(1, 16'h6000, 8'h3C, "rom.read");

        // Randomized traffic on both banks
        for (int c = 0; c < 3000; c++) begin
            tick();
            drv(0, ($urandom % 4) != 0, $urandom % 2, 16'($urandom % 32'h4000), 8'($urandom));
            drv(1, ($urandom % 4) != 0, $urandom % 2,
                16'($urandom_range(32'h8100, 32'h5F00)), 8'($urandom));
        end
        tick(); drv(0, 0, 0, 16'h0000, 8'h00); drv(1, 0, 0, 16'h0000, 8'h00);

        // Reset mid-clear: clear restarts in full
        rst_a = 1'b1;
        tick(); rst_a = 1'b0;
        repeat (100) tick();
        rst_a = 1'b1;
        tick(); rst_a = 1'b0;
        count_busy_a(1'b0, n);
        chk("reclear_len", 32'(n), 32'd2048);
        for (int k = 0; k <= 2048; k++) begin
            tick();
            if (k < 2048) drv(0, 1, 0, 16'(k), 8'h00);
            else          drv(0, 0, 0, 16'h0000, 8'h00);
            if (k > 0) begin
                @(negedge clk);
                chk("sweep", {23'h0, ifa.dout_valid, ifa.dout}, 32'h100);
            end
        end

        repeat (2) tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", passed, total);
        $fatal(1, "watchdog");
    end

endmodule
